rv32_dmem_bridge: RTL

- Data-memory bridge directly downstream of the core's memory stage.
- Converts the core's single-cycle data port (data_enable/data_read/data_addr/data_store/data_fetch) into a req/gnt/rvalid bus transaction.
- Handles byte/halfword/word stores with byte strobes, and loads with sign or zero extension.
- Raises busy while a transaction is outstanding, so the pipeline can stall until data returns.

---
 rtl/rv32_mem_pkg.sv | 38 +++
 rtl/rv32_dmem_bridge_if.sv | 23 ++
 rtl/rv32_load_align.sv | 33 +++
 rtl/rv32_dmem_bridge.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 data-memory path: funct3 codes, bridge FSM
// states and the access legality check.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } dmem_state_t;

    // Illegal funct3 encodings are reported as not-ok, same as misalignment.
    function automatic logic access_ok(input logic       is_read,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = ~addr_lo[0];
            F3_LW:   ok = (addr_lo == 2'b00);
            F3_LBU:  ok = is_read;
            F3_LHU:  ok = is_read & ~addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rv32_dmem_bridge_if.sv
// Request/grant/rvalid data bus between the bridge (master) and memory (slave).
interface rv32_dmem_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_wstrb;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/rv32_load_align.sv
// Combinational load lane select with sign/zero extension for RV32I loads.
module rv32_load_align
    import rv32_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = lanes[addr_lo];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LHU:  result = {16'h0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/rv32_dmem_bridge.sv
// Bridges the core's single-cycle data port onto a req/gnt/rvalid bus,
// stalling the pipeline via busy while a transaction is outstanding.
module rv32_dmem_bridge
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int          ADDR_W         = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_enable,
    input  logic                data_read,
    input  logic [2:0]          data_funct3,
    input  logic [31:0]         data_addr,
    input  logic [31:0]         data_store,
    output logic [31:0]         data_fetch,
    output logic                busy,
    output logic                access_err,
    rv32_dmem_bridge_if.master  bus
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_t      state_reg, state_next;
    logic             read_reg;
    logic [2:0]       f3_reg;
    logic [31:0]      addr_reg;
    logic [31:0]      wdata_reg;
    logic [3:0]       wstrb_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      data_fetch_reg;

    logic [31:0] wdata_enc;
    logic [3:0]  wstrb_enc;
    logic        ok_now;
    logic        timeout_hit;
    logic        load_done;
    logic        timeout_abort;
    logic [31:0] load_result;

    rv32_load_align u_align (
        .rdata   (bus.bus_rdata),
        .addr_lo (addr_reg[1:0]),
        .funct3  (f3_reg),
        .result  (load_result)
    );

    // Store lanes are computed from the live inputs so they can be captured in IDLE.
    always_comb begin
        wdata_enc = data_store;
        wstrb_enc = 4'b1111;
        case (data_funct3[1:0])
            2'b00: begin
                wstrb_enc = 4'b0001 << data_addr[1:0];
                wdata_enc = {4{data_store[7:0]}};
            end
            2'b01: begin
                wstrb_enc = 4'b0011 << data_addr[1:0];
                wdata_enc = {2{data_store[15:0]}};
            end
            default: begin
                wstrb_enc = 4'b1111;
                wdata_enc = data_store;
            end
        endcase
    end

    always_comb begin
        ok_now      = access_ok(data_read, data_funct3, data_addr[1:0]);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_reg == TO_LAST);
        load_done   = ((state_reg == ST_REQ) && bus.bus_gnt && read_reg && bus.bus_rvalid)
                   || ((state_reg == ST_WAIT) && bus.bus_rvalid);
        // A response arriving in the final cycle wins over the timeout.
        timeout_abort = timeout_hit &&
                        (((state_reg == ST_REQ) && !bus.bus_gnt) ||
                         ((state_reg == ST_WAIT) && !bus.bus_rvalid));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (data_enable) begin
                    state_next = ok_now ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (bus.bus_gnt) begin
                    state_next = (!read_reg || bus.bus_rvalid) ? ST_DONE : ST_WAIT;
                end else if (timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_WAIT: begin
                if (bus.bus_rvalid || timeout_hit) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_reg       <= 1'b0;
            f3_reg         <= 3'b000;
            addr_reg       <= 32'h0;
            wdata_reg      <= 32'h0;
            wstrb_reg      <= 4'b0000;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
            data_fetch_reg <= 32'h0;
        end else begin
            if ((state_reg == ST_IDLE) && data_enable) begin
                read_reg  <= data_read;
                f3_reg    <= data_funct3;
                addr_reg  <= data_addr;
                wdata_reg <= wdata_enc;
                wstrb_reg <= data_read ? 4'b0000 : wstrb_enc;
                err_reg   <= ~ok_now;
                cnt_reg   <= '0;
            end
            if ((state_reg == ST_REQ) || (state_reg == ST_WAIT)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (timeout_abort) begin
                err_reg <= 1'b1;
            end
            if (load_done) begin
                data_fetch_reg <= load_result;
            end else if (timeout_abort && read_reg) begin
                data_fetch_reg <= 32'h0;
            end
        end
    end

    // Bus fields are only driven while requesting so the bus idles at zero.
    always_comb begin
        bus.bus_req   = (state_reg == ST_REQ);
        bus.bus_we    = (state_reg == ST_REQ) && !read_reg;
        bus.bus_addr  = (state_reg == ST_REQ) ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
        bus.bus_wdata = (state_reg == ST_REQ) ? wdata_reg : 32'h0;
        bus.bus_wstrb = (state_reg == ST_REQ) ? wstrb_reg : 4'b0000;
        busy          = rst_n && (((state_reg == ST_IDLE) && data_enable) ||
                                  (state_reg == ST_REQ) || (state_reg == ST_WAIT));
        access_err    = (state_reg == ST_DONE) && err_reg;
        data_fetch    = data_fetch_reg;
    end

endmodule
